// File: rtl/and_snina_param.sv
// Masked AND over SHARES shares with COPIES replicas per share. A fault is detected
// when any per-domain product term differs across replicas.
module and_snina_param #(
  parameter int unsigned SHARES   = 3,
  parameter int unsigned COPIES   = 2,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SUPPRESS = 1'b0,
  parameter bit          LOCK     = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [SHARES*COPIES-1:0]             port_a,
  input  logic [SHARES*COPIES-1:0]             port_b,
  input  logic [SHARES*(SHARES-1)/2-1:0]       port_r,
  output logic                                 out_valid,
  output logic [SHARES*COPIES-1:0]             port_c,
  output logic [SHARES-1:0]                    port_errorFlag,
  output logic                                 error_sticky,
  output logic [CNT_W-1:0]                     error_count
);

  localparam int unsigned W = SHARES * COPIES;

  // Pair (i,j), i<j, enumerated row by row: (0,1),(0,2),...,(1,2),...
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    return i * SHARES - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [SHARES-1:0][SHARES-1:0][COPIES-1:0] u_d, u_q;
  logic [W-1:0]      c_d, c_q;
  logic [SHARES-1:0] flag_d, flag_q;
  logic              v1_q, v2_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_beat;

  always_comb begin
    u_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        for (int unsigned k = 0; k < COPIES; k++) begin
          if (i == j) begin
            u_d[i][j][k] = port_a[i*COPIES+k] & port_b[j*COPIES+k];
          end else if (i < j) begin
            u_d[i][j][k] = (port_a[i*COPIES+k] & port_b[j*COPIES+k]) ^ port_r[pair_idx(i, j)];
          end else begin
            u_d[i][j][k] = (port_a[i*COPIES+k] & port_b[j*COPIES+k]) ^ port_r[pair_idx(j, i)];
          end
        end
      end
    end
  end

  always_comb begin
    c_d    = '0;
    flag_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        for (int unsigned k = 0; k < COPIES; k++) begin
          c_d[i*COPIES+k] = c_d[i*COPIES+k] ^ u_q[i][j][k];
        end
        // Any replica disagreeing with copy 0 means the copies are not all equal.
        if (u_q[i][j] != {COPIES{u_q[i][j][0]}}) begin
          flag_d[i] = 1'b1;
        end
      end
    end
  end

  assign port_errorFlag = flag_q & {SHARES{v2_q}};
  assign err_beat       = v2_q & (|port_errorFlag);
  assign port_c         = (SUPPRESS && err_beat) ? '0 : c_q;
  assign out_valid      = LOCK ? (v2_q & ~sticky_q) : v2_q;
  assign error_sticky   = sticky_q;
  assign error_count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      u_q      <= '0;
      c_q      <= '0;
      flag_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        u_q <= u_d;
      end
      if (v1_q) begin
        c_q    <= c_d;
        flag_q <= flag_d;
      end
      if (err_beat) begin
        sticky_q <= 1'b1;
        if (count_q != {CNT_W{1'b1}}) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_and_snina_param.sv
// Scoreboard bench for and_snina_param: three instances (plain, suppress+lock, narrow counter)
// share one stimulus stream; expected beats are queued at drive time and checked on output.
module tb_and_snina_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [5:0] a, b;
  logic [2:0] r;

  logic       ov0, ov1, ov2;
  logic [5:0] c0, c1, c2;
  logic [2:0] f0, f1, f2;
  logic       st0, st1, st2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  and_snina_param #(.SHARES(3), .COPIES(2), .CNT_W(8), .SUPPRESS(1'b0), .LOCK(1'b0)) u_plain (
    .clk(clk), .reset(reset), .in_valid(in_valid), .port_a(a), .port_b(b), .port_r(r),
    .out_valid(ov0), .port_c(c0), .port_errorFlag(f0), .error_sticky(st0), .error_count(cnt0)
  );

  and_snina_param #(.SHARES(3), .COPIES(2), .CNT_W(8), .SUPPRESS(1'b1), .LOCK(1'b1)) u_lock (
    .clk(clk), .reset(reset), .in_valid(in_valid), .port_a(a), .port_b(b), .port_r(r),
    .out_valid(ov1), .port_c(c1), .port_errorFlag(f1), .error_sticky(st1), .error_count(cnt1)
  );

  and_snina_param #(.SHARES(3), .COPIES(2), .CNT_W(2), .SUPPRESS(1'b0), .LOCK(1'b0)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .port_a(a), .port_b(b), .port_r(r),
    .out_valid(ov2), .port_c(c2), .port_errorFlag(f2), .error_sticky(st2), .error_count(cnt2)
  );

  typedef struct {
    int         due;
    logic [5:0] c;
    logic [2:0] fl;
    logic [5:0] a;
    logic [5:0] b;
  } item_t;

  item_t sb[$];
  item_t it;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    m_cnt   = 0;
  bit    m_sticky = 1'b0;
  bit    armed    = 1'b0;
  bit    is_due;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] rep(input logic [2:0] sh);
    logic [5:0] v;
    for (int s = 0; s < 3; s++) begin
      v[s*2]   = sh[s];
      v[s*2+1] = sh[s];
    end
    return v;
  endfunction

  // Reference gadget: products per domain pair and copy, pair bit p(i,j)=i+j-1 for 3 shares.
  task automatic model(input logic [5:0] ma, input logic [5:0] mb, input logic [2:0] mr,
                       output logic [5:0] mc, output logic [2:0] mf);
    logic [1:0] u;
    mc = '0;
    mf = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 2; k++) begin
          u[k] = ma[i*2+k] & mb[j*2+k];
          if (i != j) u[k] = u[k] ^ mr[i+j-1];
          mc[i*2+k] = mc[i*2+k] ^ u[k];
        end
        if (u[0] != u[1]) mf[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [1:0] recomb(input logic [5:0] v);
    return {v[1] ^ v[3] ^ v[5], v[0] ^ v[2] ^ v[4]};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      is_due = 1'b0;
      if (sb.size() != 0 && sb[0].due == cyc) begin
        is_due = 1'b1;
        it = sb.pop_front();
      end
      check_eq("valid", ov0, is_due);
      check_eq("valid_lock", ov1, is_due & ~m_sticky);
      check_eq("valid_sat", ov2, is_due);
      check_eq("sticky", st0, m_sticky);
      check_eq("sticky_lock", st1, m_sticky);
      check_eq("count", cnt0, sat(m_cnt, 255));
      check_eq("count_lock", cnt1, sat(m_cnt, 255));
      check_eq("count_sat", cnt2, sat(m_cnt, 3));
      if (is_due) begin
        check_eq("port_c", c0, it.c);
        check_eq("flags", f0, it.fl);
        check_eq("flags_lock", f1, it.fl);
        check_eq("port_c_supp", c1, (it.fl != 0) ? 6'd0 : it.c);
        check_eq("recombine", recomb(c0), recomb(it.a) & recomb(it.b));
        if (it.fl != 0) begin
          m_sticky = 1'b1;
          m_cnt++;
        end
      end else begin
        check_eq("flags_idle", f0, 0);
      end
    end
    // Account for what the DUTs sample on the coming rising edge.
    if (reset) begin
      sb.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
      armed    = 1'b1;
    end else if (armed && in_valid) begin
      it.due = cyc + 2;
      it.a   = a;
      it.b   = b;
      model(a, b, r, it.c, it.fl);
      sb.push_back(it);
    end
  end

  task automatic beat(input logic [5:0] ta, input logic [5:0] tb, input logic [2:0] tr);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    r = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ra, rb;
    reset    = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    r = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    beat(rep(3'b001), rep(3'b001), 3'b000);
    idle(3);
    beat(rep(3'b001), rep(3'b001), 3'b101);
    beat(rep(3'b001), rep(3'b001), 3'b101);
    idle(2);
    for (int n = 0; n < 20; n++) begin
      ra = rep(3'($urandom));
      rb = rep(3'($urandom));
      beat(ra, rb, 3'($urandom));
    end
    idle(3);

    // Share 1 copy 1 flipped: only domain 1 disagrees across replicas.
    beat(rep(3'b001) | 6'b001000, rep(3'b001), 3'b000);
    idle(2);
    beat(rep(3'b011), rep(3'b101), 3'b110);
    idle(3);

    // Reset lands while a beat is in flight and while in_valid is high.
    beat(rep(3'b111), rep(3'b111), 3'b010);
    reset = 1'b1;
    beat(rep(3'b001), rep(3'b001), 3'b000);
    reset = 1'b0;
    idle(4);
    beat(rep(3'b110), rep(3'b011), 3'b001);
    idle(3);

    for (int n = 0; n < 5; n++) begin
      ra = rep(3'($urandom)) ^ (6'b000010 << (2 * (n % 3)));
      rb = rep(3'b111);
      beat(ra, rb, 3'($urandom));
      idle(1);
    end
    for (int n = 0; n < 10; n++) begin
      beat(6'($urandom), 6'($urandom), 3'($urandom));
    end
    idle(4);

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
